// File: rtl/decodificador_secded_pipe.sv
// Two-stage pipelined Hamming SECDED decoder with valid/ready handshake and
// saturating single/double error counters on the delivered results.
module decodificador_secded_pipe #(
  parameter  int R      = 3,
  parameter  int CNT_W  = 16,
  localparam int CW_W   = 2**R,
  localparam int DATA_W = CW_W - R - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW_W-1:0]   cw_in,
  input  logic              correct_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic [R:0]        sindrome,
  output logic              err_single,
  output logic              err_double,
  output logic [CNT_W-1:0]  cnt_single,
  output logic [CNT_W-1:0]  cnt_double,
  input  logic              clr_cnt
);

  logic              r_s1_valid;
  logic [CW_W-1:0]   r_s1_cw;
  logic              r_s1_corr;
  logic              r_s2_valid;
  logic [DATA_W-1:0] r_data;
  logic [R:0]        r_sindrome;
  logic              r_err_single;
  logic              r_err_double;
  logic [CNT_W-1:0]  r_cnt_single;
  logic [CNT_W-1:0]  r_cnt_double;

  logic              w_s2_load;
  logic              w_s1_load;
  logic              w_out_hs;
  logic [R-1:0]      w_s;
  logic              w_g;
  logic              w_single;
  logic              w_double;
  logic [CW_W-1:0]   w_fixed;
  logic [DATA_W-1:0] w_data;

  // A stage may load whenever it is empty or its content leaves in the same cycle.
  assign w_s2_load = !r_s2_valid || out_ready;
  assign w_s1_load = !r_s1_valid || w_s2_load;
  assign in_ready  = w_s1_load;
  assign w_out_hs  = r_s2_valid && out_ready;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned and infers a latch.
  always_comb begin
    int k;
    w_s = '0;
    for (int i = 0; i < CW_W - 1; i++) begin
      if (r_s1_cw[i]) w_s = w_s ^ R'(i + 1);
    end
    w_g      = ^r_s1_cw;
    w_single = w_g;
    w_double = !w_g && (w_s != '0);

    // Only a true single error in the Hamming part gets a bit flipped; g0-only errors leave data intact.
    w_fixed = r_s1_cw;
    if (r_s1_corr && w_g && (w_s != '0)) begin
      for (int i = 0; i < CW_W - 1; i++) begin
        if (R'(i + 1) == w_s) w_fixed[i] = ~w_fixed[i];
      end
    end

    w_data = '0;
    k      = 0;
    for (int p = 1; p < CW_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        w_data[k] = w_fixed[p-1];
        k         = k + 1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid   <= 1'b0;
      r_s1_cw      <= '0;
      r_s1_corr    <= 1'b0;
      r_s2_valid   <= 1'b0;
      r_data       <= '0;
      r_sindrome   <= '0;
      r_err_single <= 1'b0;
      r_err_double <= 1'b0;
    end else begin
      if (w_s1_load) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_cw   <= cw_in;
          r_s1_corr <= correct_en;
        end
      end
      if (w_s2_load) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_data       <= w_data;
          r_sindrome   <= {w_g, w_s};
          r_err_single <= w_single;
          r_err_double <= w_double;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      r_cnt_single <= '0;
      r_cnt_double <= '0;
    end else if (w_out_hs) begin
      if (r_err_single && (r_cnt_single != '1)) r_cnt_single <= r_cnt_single + 1'b1;
      if (r_err_double && (r_cnt_double != '1)) r_cnt_double <= r_cnt_double + 1'b1;
    end
  end

  assign out_valid  = r_s2_valid;
  assign data_out   = r_data;
  assign sindrome   = r_sindrome;
  assign err_single = r_err_single;
  assign err_double = r_err_double;
  assign cnt_single = r_cnt_single;
  assign cnt_double = r_cnt_double;

endmodule

// File: tb/tb_decodificador_secded_pipe.sv
// Directed bench for decodificador_secded_pipe (R=3): a default-width instance
// plus a CNT_W=2 instance sharing the same stimulus for counter saturation.
module tb_decodificador_secded_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] cw_in;
  logic       correct_en;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] data_out;
  logic [3:0] sindrome;
  logic       err_single;
  logic       err_double;
  logic [15:0] cnt_single;
  logic [15:0] cnt_double;
  logic       clr_cnt;

  logic       s_in_ready;
  logic       s_out_valid;
  logic [3:0] s_data_out;
  logic [3:0] s_sindrome;
  logic       s_err_single;
  logic       s_err_double;
  logic [1:0] s_cnt_single;
  logic [1:0] s_cnt_double;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cs   = 0;
  int exp_cd   = 0;

  always #5 clk = ~clk;

  decodificador_secded_pipe #(.R(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .cw_in(cw_in), .correct_en(correct_en), .out_valid(out_valid),
    .out_ready(out_ready), .data_out(data_out), .sindrome(sindrome),
    .err_single(err_single), .err_double(err_double),
    .cnt_single(cnt_single), .cnt_double(cnt_double), .clr_cnt(clr_cnt)
  );

  decodificador_secded_pipe #(.R(3), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .cw_in(cw_in), .correct_en(correct_en), .out_valid(s_out_valid),
    .out_ready(out_ready), .data_out(s_data_out), .sindrome(s_sindrome),
    .err_single(s_err_single), .err_double(s_err_double),
    .cnt_single(s_cnt_single), .cnt_double(s_cnt_double), .clr_cnt(clr_cnt)
  );

  // Present one word for a single cycle, then wait (bounded) for its result.
  task automatic run_word(input logic [7:0] cw, input logic corr, input string name);
    @(negedge clk);
    in_valid   = 1'b1;
    cw_in      = cw;
    correct_en = corr;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 8 && !out_valid; i++) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s timeout: out_valid=%b required 1", name, out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; cw_in = '0; correct_en = 1'b1;
    out_ready = 1'b1; clr_cnt = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({out_valid, in_ready, data_out, sindrome, err_single, err_double} !== 12'b0100_0000_0000) begin
      n_fail++;
      $display("FAIL reset_outputs: ov=%b ir=%b d=%b s=%b es=%b ed=%b required ov=0 ir=1 rest 0",
               out_valid, in_ready, data_out, sindrome, err_single, err_double);
    end
    n_checks++;
    if (cnt_single !== 16'd0 || cnt_double !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_counters: cs=%0d cd=%0d required 0 0", cnt_single, cnt_double);
    end
  endtask

  task automatic test_clean_latency();
    @(negedge clk);
    in_valid = 1'b1; cw_in = 8'h55; correct_en = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_early: out_valid=%b required 0 after first edge", out_valid);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL latency_second: out_valid=%b required 1 after second edge", out_valid);
    end
    n_checks++;
    if (data_out !== 4'b1011 || sindrome !== 4'b0000 || err_single !== 1'b0 || err_double !== 1'b0) begin
      n_fail++;
      $display("FAIL clean_word: d=%b s=%b es=%b ed=%b required 1011 0000 0 0",
               data_out, sindrome, err_single, err_double);
    end
    @(negedge clk);
    n_checks++;
    if (cnt_single !== 16'(exp_cs) || cnt_double !== 16'(exp_cd)) begin
      n_fail++;
      $display("FAIL clean_counters: cs=%0d cd=%0d required %0d %0d", cnt_single, cnt_double, exp_cs, exp_cd);
    end
  endtask

  task automatic test_single();
    run_word(8'h45, 1'b1, "single_corr");
    n_checks++;
    if (data_out !== 4'b1011 || sindrome !== 4'b1101 || err_single !== 1'b1 || err_double !== 1'b0) begin
      n_fail++;
      $display("FAIL single_corr: d=%b s=%b es=%b ed=%b required 1011 1101 1 0",
               data_out, sindrome, err_single, err_double);
    end
    @(negedge clk);
    exp_cs++;
    n_checks++;
    if (cnt_single !== 16'(exp_cs)) begin
      n_fail++;
      $display("FAIL single_count: cs=%0d required %0d", cnt_single, exp_cs);
    end
    run_word(8'h45, 1'b0, "single_raw");
    n_checks++;
    if (data_out !== 4'b1001 || sindrome !== 4'b1101 || err_single !== 1'b1 || err_double !== 1'b0) begin
      n_fail++;
      $display("FAIL single_raw: d=%b s=%b es=%b ed=%b required 1001 1101 1 0",
               data_out, sindrome, err_single, err_double);
    end
    @(negedge clk);
    exp_cs++;
  endtask

  task automatic test_g0_only();
    run_word(8'hD5, 1'b1, "g0_only");
    n_checks++;
    if (data_out !== 4'b1011 || sindrome !== 4'b1000 || err_single !== 1'b1 || err_double !== 1'b0) begin
      n_fail++;
      $display("FAIL g0_only: d=%b s=%b es=%b ed=%b required 1011 1000 1 0",
               data_out, sindrome, err_single, err_double);
    end
    @(negedge clk);
    exp_cs++;
  endtask

  task automatic test_double();
    run_word(8'h41, 1'b1, "double");
    n_checks++;
    if (data_out !== 4'b1000 || sindrome !== 4'b0110 || err_single !== 1'b0 || err_double !== 1'b1) begin
      n_fail++;
      $display("FAIL double: d=%b s=%b es=%b ed=%b required 1000 0110 0 1",
               data_out, sindrome, err_single, err_double);
    end
    @(negedge clk);
    exp_cd++;
    n_checks++;
    if (cnt_double !== 16'(exp_cd) || cnt_single !== 16'(exp_cs)) begin
      n_fail++;
      $display("FAIL double_count: cs=%0d cd=%0d required %0d %0d", cnt_single, cnt_double, exp_cs, exp_cd);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; cw_in = 8'h55; correct_en = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_ready_one: in_ready=%b required 1 with one stage full", in_ready);
    end
    cw_in = 8'h45;
    @(negedge clk);
    cw_in = 8'h41;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_ready_full: in_ready=%b required 0 with both stages full", in_ready);
    end
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (out_valid !== 1'b1 || data_out !== 4'b1011 || sindrome !== 4'b0000 || err_single !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold cycle %0d: ov=%b d=%b s=%b es=%b required 1 1011 0000 0",
                 c, out_valid, data_out, sindrome, err_single);
      end
      @(negedge clk);
    end
    n_checks++;
    if (cnt_single !== 16'(exp_cs) || cnt_double !== 16'(exp_cd)) begin
      n_fail++;
      $display("FAIL bp_no_count: cs=%0d cd=%0d required %0d %0d", cnt_single, cnt_double, exp_cs, exp_cd);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || data_out !== 4'b1011 || sindrome !== 4'b1101 || err_single !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_second: ov=%b d=%b s=%b es=%b required 1 1011 1101 1",
               out_valid, data_out, sindrome, err_single);
    end
    @(negedge clk);
    exp_cs++;
    n_checks++;
    if (out_valid !== 1'b1 || data_out !== 4'b1000 || sindrome !== 4'b0110 || err_double !== 1'b1
        || cnt_single !== 16'(exp_cs)) begin
      n_fail++;
      $display("FAIL drain_third: ov=%b d=%b s=%b ed=%b cs=%0d required 1 1000 0110 1 %0d",
               out_valid, data_out, sindrome, err_double, cnt_single, exp_cs);
    end
    @(negedge clk);
    exp_cd++;
    n_checks++;
    if (out_valid !== 1'b0 || cnt_double !== 16'(exp_cd) || cnt_single !== 16'(exp_cs)) begin
      n_fail++;
      $display("FAIL drain_end: ov=%b cs=%0d cd=%0d required 0 %0d %0d",
               out_valid, cnt_single, cnt_double, exp_cs, exp_cd);
    end
  endtask

  task automatic test_saturation_clear();
    @(negedge clk);
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    exp_cs = 0; exp_cd = 0;
    n_checks++;
    if (cnt_single !== 16'd0 || cnt_double !== 16'd0 || s_cnt_single !== 2'd0) begin
      n_fail++;
      $display("FAIL clear: cs=%0d cd=%0d cs2=%0d required 0 0 0", cnt_single, cnt_double, s_cnt_single);
    end
    for (int w = 0; w < 5; w++) begin
      run_word(8'h45, 1'b1, "sat_word");
      @(negedge clk);
      exp_cs++;
    end
    n_checks++;
    if (s_cnt_single !== 2'd3 || cnt_single !== 16'(exp_cs)) begin
      n_fail++;
      $display("FAIL saturate: cs2=%0d cs=%0d required 3 %0d", s_cnt_single, cnt_single, exp_cs);
    end
    run_word(8'h45, 1'b1, "clr_hs");
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    exp_cs = 0;
    n_checks++;
    if (cnt_single !== 16'd0 || s_cnt_single !== 2'd0) begin
      n_fail++;
      $display("FAIL clr_priority: cs=%0d cs2=%0d required 0 0", cnt_single, s_cnt_single);
    end
  endtask

  task automatic test_reset_mid();
    run_word(8'h41, 1'b1, "pre_reset");
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; cw_in = 8'h55;
    repeat (2) @(negedge clk);
    cw_in = 8'h45;
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || cnt_double !== 16'd1) begin
      n_fail++;
      $display("FAIL prefill: ir=%b ov=%b cd=%0d required 0 1 1", in_ready, out_valid, cnt_double);
    end
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || data_out !== 4'd0 || cnt_double !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_mid: ov=%b ir=%b d=%b cd=%0d required 0 1 0000 0",
               out_valid, in_ready, data_out, cnt_double);
    end
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flush: out_valid=%b required 0 (in-flight words discarded)", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_clean_latency();
    test_single();
    test_g0_only();
    test_double();
    test_back_to_back();
    test_saturation_clear();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
